// File: rtl/bat_amateur_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// RAM direction constants and default bus widths.
package bat_amateur_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam logic RAM_WRITE = 1'b1;
  localparam logic RAM_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_OWN_CPU,   // CPU drives the RAM strobes and the address register
    ST_LD_ADDR,   // address register <- loader address
    ST_LD_ACC,    // loader RAM access strobe
    ST_LD_RESP,   // read data returned, transfer acknowledged
    ST_RESTORE    // address register <- saved CPU address
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single MAR/RAM port between the microcode
// controller and an external loader/debug port.
//
// Ports:
//   CLK, RST                 clock (posedge), async active-low reset
//   CPU_MAR_LOAD/RAM_EN/RW   controller strobes; CPU_BUS address / write data
//   CPU_BOUNDARY             controller is at an instruction boundary
//   CPU_HOLD                 freezes the uOP counter while the loader owns memory
//   LD_REQ/WE/ADDR/WDATA     loader request (held stable until LD_ACK)
//   LD_GNT, LD_ACK, LD_RDATA loader grant, one-cycle ack, read data with ack
//   MEM_ADDR/EN/WE/WDATA     RAM port; MEM_RDATA valid one cycle after read EN
module mem_bus_arbiter
  import bat_amateur_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_MAR_LOAD,
  input  logic              CPU_RAM_EN,
  input  logic              CPU_RAM_RW,
  input  logic [DATA_W-1:0] CPU_BUS,
  input  logic              CPU_BOUNDARY,
  output logic              CPU_HOLD,
  input  logic              LD_REQ,
  input  logic              LD_WE,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_WDATA,
  output logic              LD_GNT,
  output logic              LD_ACK,
  output logic [DATA_W-1:0] LD_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t        state, state_d;
  logic [ADDR_W-1:0] mar, saved_addr;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  burst_cnt;
  logic              eligible;
  logic              we_q;      // direction of the transfer in flight
  logic              grant;
  logic              rd_capture;

  // Grant is gated by reset so HOLD stays low while RST is asserted even
  // if the loader keeps requesting.
  assign grant = RST && (state == ST_OWN_CPU) && LD_REQ && CPU_BOUNDARY && eligible;

  // Mealy term: the controller samples HOLD in the grant cycle itself, so
  // its counter never steps past the boundary.
  assign CPU_HOLD = (state != ST_OWN_CPU) || grant;

  // LD_WE may change during LD_RESP (next request), so direction is latched.
  assign rd_capture = (state == ST_LD_RESP) && (we_q == RAM_READ);
  assign LD_RDATA   = rd_capture ? MEM_RDATA : rdata_q;
  assign MEM_ADDR   = mar;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    MEM_EN    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_WDATA = CPU_BUS;
    LD_ACK    = 1'b0;
    LD_GNT    = 1'b0;
    unique case (state)
      ST_OWN_CPU: begin
        // CPU strobes in the grant cycle are dropped; no writes under reset.
        MEM_EN = CPU_RAM_EN && !grant;
        MEM_WE = MEM_EN && (CPU_RAM_RW == RAM_WRITE) && RST;
        if (grant) state_d = ST_LD_ADDR;
      end
      ST_LD_ADDR: begin
        LD_GNT  = 1'b1;
        state_d = ST_LD_ACC;
      end
      ST_LD_ACC: begin
        LD_GNT    = 1'b1;
        MEM_EN    = 1'b1;
        MEM_WE    = LD_WE;
        MEM_WDATA = LD_WDATA;
        state_d   = ST_LD_RESP;
      end
      ST_LD_RESP: begin
        LD_GNT = 1'b1;
        LD_ACK = 1'b1;
        if (LD_REQ && (burst_cnt < BURST_LAST)) state_d = ST_LD_ADDR;
        else                                     state_d = ST_RESTORE;
      end
      ST_RESTORE: state_d = ST_OWN_CPU;
      default:    state_d = ST_OWN_CPU;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_OWN_CPU;
      mar        <= '0;
      saved_addr <= '0;
      rdata_q    <= '0;
      burst_cnt  <= '0;
      eligible   <= 1'b1;
      we_q       <= RAM_READ;
    end else begin
      state <= state_d;
      unique case (state)
        ST_OWN_CPU: begin
          if (CPU_BOUNDARY) eligible <= 1'b1;
          // Grant beats a simultaneous MAR load: the pre-load value is saved.
          if (grant) begin
            saved_addr <= mar;
            burst_cnt  <= '0;
          end else if (CPU_MAR_LOAD) begin
            mar <= CPU_BUS[ADDR_W-1:0];
          end
        end
        ST_LD_ADDR: mar  <= LD_ADDR;
        ST_LD_ACC:  we_q <= LD_WE;
        ST_LD_RESP: begin
          if (rd_capture) rdata_q <= MEM_RDATA;
          if (state_d == ST_LD_ADDR) burst_cnt <= burst_cnt + 1'b1;
        end
        ST_RESTORE: begin
          mar      <= saved_addr;
          eligible <= 1'b0;   // CPU must reach another boundary first
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Stimulus pushes expected RAM writes
// and loader acks into queues; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CPU_MAR_LOAD, CPU_RAM_EN, CPU_RAM_RW, CPU_BOUNDARY;
  logic [7:0] CPU_BUS;
  logic       CPU_HOLD;
  logic       LD_REQ, LD_WE;
  logic [7:0] LD_ADDR, LD_WDATA;
  logic       LD_GNT, LD_ACK;
  logic [7:0] LD_RDATA;
  logic [7:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic       MEM_EN, MEM_WE;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_ack[$];   // LD_RDATA expected with each ack
  wr_t        w;
  logic [7:0] a;
  logic [7:0] ram [256];

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
    .CLK(CLK), .RST(RST),
    .CPU_MAR_LOAD(CPU_MAR_LOAD), .CPU_RAM_EN(CPU_RAM_EN), .CPU_RAM_RW(CPU_RAM_RW),
    .CPU_BUS(CPU_BUS), .CPU_BOUNDARY(CPU_BOUNDARY), .CPU_HOLD(CPU_HOLD),
    .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
    .LD_GNT(LD_GNT), .LD_ACK(LD_ACK), .LD_RDATA(LD_RDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  // Synchronous RAM; location 0x7F holds 0x3C after reset.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 127) ? 8'h3C : 8'h00;
      MEM_RDATA <= 8'h00;
    end else if (MEM_EN) begin
      if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
      else        MEM_RDATA     <= ram[MEM_ADDR];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every RAM write and every loader ack must have been predicted.
  always @(negedge CLK) begin
    if (RST && MEM_EN && MEM_WE) begin
      if (exp_wr.size() == 0) begin
        fail_now($sformatf("unexpected_write addr=0x%0h data=0x%0h", MEM_ADDR, MEM_WDATA));
      end else begin
        w = exp_wr.pop_front();
        check("wr_addr", MEM_ADDR, w.addr);
        check("wr_data", MEM_WDATA, w.data);
      end
    end
    if (LD_ACK) begin
      if (exp_ack.size() == 0) begin
        fail_now("unexpected_ack");
      end else begin
        a = exp_ack.pop_front();
        check("ack_rdata", LD_RDATA, a);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_mar(input logic [7:0] v);
    step();
    CPU_MAR_LOAD = 1'b1;
    CPU_BUS      = v;
    step();
    CPU_MAR_LOAD = 1'b0;
    CPU_BUS      = 8'h00;
  endtask

  // One boundary with no request pending: re-arms loader eligibility.
  task automatic rearm();
    step();
    CPU_BOUNDARY = 1'b1;
    step();
    CPU_BOUNDARY = 1'b0;
  endtask

  // Grant cycle: request arrives with BOUNDARY high.
  task automatic start(input logic we, input logic [7:0] ad, input logic [7:0] wd);
    step();
    LD_REQ = 1'b1; LD_WE = we; LD_ADDR = ad; LD_WDATA = wd;
    CPU_BOUNDARY = 1'b1;
    @(negedge CLK);
    check("grant_cycle_hold", CPU_HOLD, 1'b1);
    check("grant_cycle_gnt", LD_GNT, 1'b0);
  endtask

  task automatic wait_ack(input string name, output int lat);
    bit got = 0;
    lat = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      CPU_BOUNDARY = 1'b0;
      CPU_MAR_LOAD = 1'b0;
      lat++;
      if (LD_ACK) got = 1;
    end
    if (!got) begin
      fail_now({name, "_ack_timeout"});
      lat = -1;
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle = 0;
    for (int i = 0; i < 10 && !idle; i++) begin
      step();
      if (!CPU_HOLD) idle = 1;
    end
    if (!idle) fail_now({name, "_release_timeout"});
  endtask

  int lat;
  int first_acks;

  initial begin
    RST = 1'b0;
    CPU_MAR_LOAD = 0; CPU_RAM_EN = 0; CPU_RAM_RW = 0; CPU_BOUNDARY = 0; CPU_BUS = 0;
    LD_REQ = 0; LD_WE = 0; LD_ADDR = 0; LD_WDATA = 0;

    // Reset values; MEM_EN follows CPU_RAM_EN, MEM_WE held low.
    step();
    CPU_RAM_EN = 1'b1; CPU_RAM_RW = 1'b1;
    @(negedge CLK);
    check("rst_hold", CPU_HOLD, 1'b0);
    check("rst_gnt", LD_GNT, 1'b0);
    check("rst_ack", LD_ACK, 1'b0);
    check("rst_addr", MEM_ADDR, 8'h00);
    check("rst_rdata", LD_RDATA, 8'h00);
    check("rst_mem_en", MEM_EN, 1'b1);
    check("rst_mem_we", MEM_WE, 1'b0);
    step();
    CPU_RAM_EN = 1'b0; CPU_RAM_RW = 1'b0;
    RST = 1'b1;

    // Loader write, cycle-by-cycle.
    load_mar(8'h12);
    check("mar_load", MEM_ADDR, 8'h12);
    exp_wr.push_back('{addr: 8'h40, data: 8'hA5});
    exp_ack.push_back(8'h00);
    start(1'b1, 8'h40, 8'hA5);                      // cycle 0
    step(); CPU_BOUNDARY = 1'b0;                    // cycle 1
    @(negedge CLK);
    check("wr_c1_gnt", LD_GNT, 1'b1);
    check("wr_c1_hold", CPU_HOLD, 1'b1);
    step(); @(negedge CLK);                         // cycle 2
    check("wr_c2_en", MEM_EN, 1'b1);
    check("wr_c2_we", MEM_WE, 1'b1);
    check("wr_c2_addr", MEM_ADDR, 8'h40);
    check("wr_c2_ack", LD_ACK, 1'b0);
    step();                                         // cycle 3
    check("wr_c3_ack", LD_ACK, 1'b1);
    LD_REQ = 1'b0;
    @(negedge CLK);
    check("wr_c3_hold", CPU_HOLD, 1'b1);
    step(); @(negedge CLK);                         // cycle 4
    check("wr_c4_hold", CPU_HOLD, 1'b1);
    check("wr_c4_gnt", LD_GNT, 1'b0);
    step(); @(negedge CLK);                         // cycle 5
    check("wr_c5_hold", CPU_HOLD, 1'b0);
    check("wr_c5_addr", MEM_ADDR, 8'h12);

    // Loader read of 0x7F.
    rearm();
    exp_ack.push_back(8'h3C);
    start(1'b0, 8'h7F, 8'h00);
    wait_ack("read", lat);
    check("read_ack_latency", lat, 3);
    LD_REQ = 1'b0;
    wait_idle("read");
    check("read_restore_addr", MEM_ADDR, 8'h12);
    check("read_rdata_held", LD_RDATA, 8'h3C);

    // Burst cap: six writes requested, four per grant.
    rearm();
    for (int i = 0; i < 6; i++) begin
      exp_wr.push_back('{addr: 8'h80 + 8'(i), data: 8'h10 + 8'(i)});
      exp_ack.push_back(8'h3C);
    end
    start(1'b1, 8'h80, 8'h10);
    first_acks = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack("burst", lat);
      if (lat > 0) first_acks++;
      LD_ADDR = 8'h81 + 8'(i); LD_WDATA = 8'h11 + 8'(i);
    end
    check("burst_first_acks", first_acks, 4);
    step(); @(negedge CLK);
    check("burst_restore_gnt", LD_GNT, 1'b0);
    check("burst_restore_hold", CPU_HOLD, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(); @(negedge CLK);
      check("burst_no_regrant_gnt", LD_GNT, 1'b0);
      check("burst_no_regrant_hold", CPU_HOLD, 1'b0);
    end
    check("burst_restore_addr", MEM_ADDR, 8'h12);
    step(); CPU_BOUNDARY = 1'b1;                    // re-arms only
    @(negedge CLK);
    check("burst_rearm_hold", CPU_HOLD, 1'b0);
    step(); CPU_BOUNDARY = 1'b0;
    @(negedge CLK);
    check("burst_rearm_gnt", LD_GNT, 1'b0);
    step();
    step(); CPU_BOUNDARY = 1'b1;                    // next boundary grants
    @(negedge CLK);
    check("burst_regrant_hold", CPU_HOLD, 1'b1);
    wait_ack("burst2", lat);
    LD_ADDR = 8'h85; LD_WDATA = 8'h15;
    wait_ack("burst2", lat);
    LD_REQ = 1'b0;
    wait_idle("burst2");

    // Boundary wait: CPU writes pass through while the loader waits.
    rearm();
    step();
    LD_REQ = 1'b1; LD_WE = 1'b1; LD_ADDR = 8'h33; LD_WDATA = 8'h77;
    CPU_RAM_EN = 1'b1; CPU_RAM_RW = 1'b1; CPU_BUS = 8'h99;
    for (int i = 0; i < 5; i++) exp_wr.push_back('{addr: 8'h12, data: 8'h99});
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("wait_hold", CPU_HOLD, 1'b0);
      check("wait_mem_en", MEM_EN, 1'b1);
      check("wait_gnt", LD_GNT, 1'b0);
      step();
    end
    CPU_RAM_EN = 1'b0; CPU_RAM_RW = 1'b0; CPU_BUS = 8'h00; CPU_BOUNDARY = 1'b1;
    exp_wr.push_back('{addr: 8'h33, data: 8'h77});
    exp_ack.push_back(8'h3C);
    @(negedge CLK);
    check("wait_grant_hold", CPU_HOLD, 1'b1);
    wait_ack("wait", lat);
    check("wait_ack_latency", lat, 3);
    LD_REQ = 1'b0;
    wait_idle("wait");

    // Grant collides with a CPU MAR load of 0x55; MAR was 0x20.
    rearm();
    load_mar(8'h20);
    step();
    LD_REQ = 1'b1; LD_WE = 1'b0; LD_ADDR = 8'h7F;
    CPU_BOUNDARY = 1'b1; CPU_MAR_LOAD = 1'b1; CPU_BUS = 8'h55;
    exp_ack.push_back(8'h3C);
    @(negedge CLK);
    check("coll_hold", CPU_HOLD, 1'b1);
    wait_ack("coll", lat);
    CPU_BUS = 8'h00;
    LD_REQ = 1'b0;
    wait_idle("coll");
    check("coll_restore_addr", MEM_ADDR, 8'h20);

    // Reset in the middle of LD_ACC: no write, no ack, MAR cleared.
    rearm();
    start(1'b1, 8'h50, 8'hEE);
    step(); CPU_BOUNDARY = 1'b0;
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_hold", CPU_HOLD, 1'b0);
    check("midrst_gnt", LD_GNT, 1'b0);
    check("midrst_ack", LD_ACK, 1'b0);
    check("midrst_addr", MEM_ADDR, 8'h00);
    check("midrst_mem_en", MEM_EN, 1'b0);
    step();
    LD_REQ = 1'b0;
    RST = 1'b1;
    repeat (4) step();
    @(negedge CLK);
    check("postrst_hold", CPU_HOLD, 1'b0);
    check("postrst_addr", MEM_ADDR, 8'h00);

    check("wr_queue_drained", exp_wr.size(), 0);
    check("ack_queue_drained", exp_ack.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
